// File: rtl/logip_pkg.sv
// Shared types and constants for the logic analyzer host link.
package logip_pkg;

    typedef logic [7:0] byte_t;

    // 12 MHz system clock at 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 104;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: recovers bytes from the synchronized RX line, strobes good
// bytes on valid_o and flags frames whose stop bit is low on frame_err_o.
module uart_rx
    import logip_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic  clk_i,
    input  logic  rst_in,
    input  logic  rx_i,
    output byte_t data_o,
    output logic  valid_o,
    output logic  frame_err_o,
    output logic  busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef logic [2:0] rx_state_e;
    localparam rx_state_e IDLE      = 3'd0;
    localparam rx_state_e START     = 3'd1;
    localparam rx_state_e DATA      = 3'd2;
    localparam rx_state_e STOP      = 3'd3;
    localparam rx_state_e WAIT_HIGH = 3'd4;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    byte_t            shift_q, shift_d;
    byte_t            data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    // Next-state logic: bit timing, sampling and frame checks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        // busy follows the state one cycle late so it drops together with the strobe
        busy_d  = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (!rx_i) begin
                    state_d = START;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = CNT_ZERO;
                    bit_d = 3'd0;
                    if (!rx_i) begin
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {rx_i, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (rx_i) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (rx_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                bit_d   = 3'd0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level timing model schedules the
// expected strobes, data and busy window per cycle; a negedge process compares.
module tb_uart_rx;

    localparam int N     = 8;
    localparam int DEPTH = 8192;

    logic       clk_i = 1'b0;
    logic       rst_in;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk_i       (clk_i),
        .rst_in      (rst_in),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Expected outputs indexed by the edge after which they are visible
    bit         exp_busy  [DEPTH];
    bit         exp_valid [DEPTH];
    bit         exp_ferr  [DEPTH];
    logic [7:0] exp_byte  [DEPTH];
    logic [7:0] model_data = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0, ferr_cnt = 0, busy_cyc = 0;
    int last_vcyc = 0, prev_vcyc = 0;
    logic [7:0] last_vdata = 8'h00, prev_vdata = 8'h00;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic void sched_busy(input int a, input int b);
        for (int i = a; i <= b; i++) exp_busy[i] = 1'b1;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Drives one frame starting right after the current edge c. The receiver sees
    // t0 = c+1, samples the stop bit at t0+H+9N = c+77, strobe visible after c+77.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold);
        int c;
        logic [9:0] bits;
        c = cyc;
        bits = {stop, b, 1'b0};
        if (stop) begin
            exp_valid[c+77] = 1'b1;
            exp_byte[c+77]  = b;
            sched_busy(c + 2, c + 77);
        end else begin
            exp_ferr[c+77] = 1'b1;
            // line rises after edge c+80+hold, seen one edge later, busy one more
            sched_busy(c + 2, c + 81 + hold);
        end
        for (int k = 0; k < 10; k++) begin
            rx_i = bits[k];
            tick(N);
        end
        if (!stop) begin
            tick(hold);
            rx_i = 1'b1;
            tick(1);
        end
    endtask

    // Low pulse shorter than H: rejected at the start check on edge c+5.
    task automatic glitch(input int g);
        int c;
        c = cyc;
        sched_busy(c + 2, c + 5);
        rx_i = 1'b0;
        tick(g);
        rx_i = 1'b1;
        tick(5 - g);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk_i) begin
        int e;
        e = cyc;
        if (!rst_in) begin
            model_data = 8'h00;
            chk("rst_data",  int'(data_o), 0);
            chk("rst_valid", int'(valid_o), 0);
            chk("rst_ferr",  int'(frame_err_o), 0);
            chk("rst_busy",  int'(busy_o), 0);
        end else begin
            if (exp_valid[e]) model_data = exp_byte[e];
            chk("valid", int'(valid_o), int'(exp_valid[e]));
            chk("ferr",  int'(frame_err_o), int'(exp_ferr[e]));
            chk("busy",  int'(busy_o), int'(exp_busy[e]));
            chk("data",  int'(data_o), int'(model_data));
            chk("excl",  int'(valid_o & frame_err_o), 0);
            if (valid_o) begin
                prev_vcyc  = last_vcyc;
                prev_vdata = last_vdata;
                last_vcyc  = e;
                last_vdata = data_o;
                valid_cnt++;
            end
            if (frame_err_o) ferr_cnt++;
            if (busy_o) busy_cyc++;
        end
    end

    initial begin
        int c, v0, f0, b0;
        logic [9:0] bits;
        rx_i   = 1'b1;
        rst_in = 1'b0;
        #2;
        chk("por_data",  int'(data_o), 8'h00);
        chk("por_valid", int'(valid_o), 0);
        chk("por_busy",  int'(busy_o), 0);
        tick(3);
        rst_in = 1'b1;

        // Long idle line: nothing must happen
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cyc;
        tick(1000);
        chk("idle_valid", valid_cnt - v0, 0);
        chk("idle_ferr",  ferr_cnt - f0, 0);
        chk("idle_busy",  busy_cyc - b0, 0);

        // Single good frame, strobe right after edge t0+76
        v0 = valid_cnt; f0 = ferr_cnt;
        c = cyc;
        send_frame(8'hA5, 1'b1, 0);
        tick(3);
        chk("a5_count", valid_cnt - v0, 1);
        chk("a5_data",  int'(last_vdata), 8'hA5);
        chk("a5_cycle", last_vcyc - c, 77);
        chk("a5_ferr",  ferr_cnt - f0, 0);

        // Back-to-back frames
        v0 = valid_cnt;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        tick(3);
        chk("b2b_count",   valid_cnt - v0, 2);
        chk("b2b_first",   int'(prev_vdata), 8'h00);
        chk("b2b_second",  int'(last_vdata), 8'hFF);
        chk("b2b_spacing", last_vcyc - prev_vcyc, 80);

        // Start glitch
        v0 = valid_cnt; b0 = busy_cyc;
        glitch(2);
        tick(2);
        chk("glitch_valid", valid_cnt - v0, 0);
        chk("glitch_busy_le5", int'((busy_cyc - b0) <= 5 && (busy_cyc - b0) > 0), 1);
        chk("glitch_idle", int'(busy_o), 0);

        // Framing error followed by a held-low break, then a good frame
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 30);
        tick(3);
        chk("ferr_count", ferr_cnt - f0, 1);
        chk("ferr_novalid", valid_cnt - v0, 0);
        chk("ferr_data_kept", int'(data_o), 8'hFF);
        send_frame(8'h81, 1'b1, 0);
        tick(3);
        chk("after_ferr_data", int'(last_vdata), 8'h81);
        chk("after_ferr_count", valid_cnt - v0, 1);

        // Reset during data bit 4 of 8'h55
        v0 = valid_cnt;
        c = cyc;
        sched_busy(c + 2, c + 43);
        bits = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < 5; k++) begin
            rx_i = bits[k];
            tick(N);
        end
        tick(4);
        chk("pre_rst_busy", int'(busy_o), 1);
        rst_in = 1'b0;
        #1;
        chk("mid_rst_data",  int'(data_o), 8'h00);
        chk("mid_rst_valid", int'(valid_o), 0);
        chk("mid_rst_busy",  int'(busy_o), 0);
        rx_i = 1'b1;
        tick(3);
        rst_in = 1'b1;
        tick(3);
        chk("mid_rst_nostrobe", valid_cnt - v0, 0);
        send_frame(8'h55, 1'b1, 0);
        tick(3);
        chk("post_rst_data", int'(last_vdata), 8'h55);

        // Randomized traffic
        for (int it = 0; it < 16; it++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind <= 6) begin
                send_frame(8'($urandom), 1'b1, 0);
            end else if (kind <= 8) begin
                send_frame(8'($urandom), 1'b0, int'($urandom_range(0, 20)));
            end else begin
                glitch(int'($urandom_range(1, 3)));
            end
            tick(int'($urandom_range(0, 5)));
        end
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-receive stage of the logic analyzer's host link. Consumes the already-synchronized RX line from the two-FF synchronizer stage and recovers 8N1 UART frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). Each good byte is delivered to the command decoder as a one-cycle strobe; malformed frames are flagged.

## Interface
Parameters:
- `CLKS_PER_BIT`, 104: clock cycles per bit period. Legal range is ≥ 4.

Ports:
- `clk_i` in 1: system clock.
- `rst_in` in 1: reset. Asynchronous, active-low.
- `rx_i` in 1: serial line. Already synchronized to `clk_i`; idle level is 1.
- `data_o` out 8: last correctly received byte. Holds its value between frames.
- `valid_o` out 1: one-cycle strobe; `data_o` is new in this cycle.
- `frame_err_o` out 1: one-cycle strobe; the stop bit was sampled 0.
- `busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- Reset (asynchronous assert, while `rst_in` = 0):
  - State is IDLE; bit counter and cycle counter are 0.
  - `data_o` = 8'h00; `valid_o`, `frame_err_o` and `busy_o` are 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE → START when `rx_i` is sampled 0. The cycle counter clears.
- START: count H = `CLKS_PER_BIT`/2 (floor) cycles, then sample `rx_i`.
  - Sample 0: go to DATA and clear the counters.
  - Sample 1: glitch. Return to IDLE with no strobe.
- DATA: every `CLKS_PER_BIT` cycles, shift `rx_i` into the shift register MSB-side, so bit 0 arrives first. After the 8th sample, go to STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample `rx_i`.
  - Sample 1: `data_o` ← shift register and pulse `valid_o`. Go to IDLE.
  - Sample 0: pulse `frame_err_o`; `data_o` is unchanged. Go to WAIT_HIGH.
- WAIT_HIGH → IDLE when `rx_i` is sampled 1. This keeps a break condition from producing repeated frames.
- The cycle counter is $clog2(`CLKS_PER_BIT`) bits wide and counts 0..`CLKS_PER_BIT`-1. It wraps to 0 on each sample event. The bit counter is 3 bits.
- `rx_i` is ignored except at sample points and in IDLE/WAIT_HIGH.
- `valid_o` and `frame_err_o` are never high in the same cycle.
- No backpressure. The consumer must take `data_o` in the `valid_o` cycle; `data_o` is stable until the next `valid_o` in any case.

## Timing
- Let t0 be the first rising edge at which IDLE samples `rx_i` = 0, and N = `CLKS_PER_BIT`.
- Start check is at edge t0+H.
- Data bit k (k = 0..7) is sampled at edge t0+H+(k+1)·N.
- Stop bit is sampled at edge t0+H+9·N.
- `valid_o` / `frame_err_o` are registered. They are high for exactly the one cycle following the stop-sample edge.
- `busy_o` rises at the edge after t0 and falls together with the strobe.
- Back-to-back frames: IDLE re-arms on the edge after the strobe. A start bit beginning immediately after a full stop bit is detected with at most 1 cycle of added latency.
- Reset mid-frame: all state and outputs return to their reset values asynchronously. No strobe is emitted. After release, the block waits in IDLE for a fresh falling level.

## Structure
- A shared package (`logip_pkg`) holds:
  - `byte_t` (logic [7:0]);
  - the default baud constant `CLKS_PER_BIT_DEFAULT` = 104 (12 MHz / 115200).
- The FSM enum `rx_state_e` is local to the module.
- Single module with no sub-module. The bit timer is an inline counter. The synchronizer is instantiated by the parent with init value 1, not inside this block.

## Test plan
All scenarios use `CLKS_PER_BIT` = 8 (H = 4).
- Send 8'hA5 with stop = 1 → exactly one `valid_o` pulse with `data_o` = 8'hA5, one cycle after edge t0+76; `frame_err_o` stays 0.
- Send 8'h00 followed immediately by 8'hFF, with no idle gap beyond the stop bit → two `valid_o` pulses, `data_o` 8'h00 then 8'hFF, pulses 80–81 cycles apart.
- Drive `rx_i` low for 2 cycles, then high → no strobe; `busy_o` high for at most 5 cycles; FSM back in IDLE.
- Send 8'h3C with stop = 0, hold line low for 30 cycles, then send 8'h81 → one `frame_err_o` pulse; `data_o` unchanged; no frame starts during the low hold; then `valid_o` with 8'h81.
- Assert `rst_in` = 0 at data bit 4 of 8'h55, then release → all outputs are 0 immediately with no strobe; a subsequent 8'h55 frame is received correctly.
- Hold `rx_i` = 1 for 1000 cycles after reset → `busy_o`, `valid_o` and `frame_err_o` all stay 0.
